// File: rtl/keyboard_accel_adapter.sv
// keyboard_accel_adapter
// Buffers key events from the scancode decoder in a small FIFO and hands them
// to the CPU through the accelerator read port. CPU writes only control flush.
// Optional build macro: KEYBOARD_ACCEL_ADAPTER_DROP_OLDEST_EN
//   undefined (default): a push into a full FIFO is dropped.
//   defined:             a push into a full FIFO overwrites the oldest entry.
// In both modes a lost event sets the sticky overflow flag.
module keyboard_accel_adapter #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic        key_released,
  output logic        accel_can_read,
  output logic        accel_can_write,
  input  logic        accel_read_enable,
  input  logic        accel_write_enable,
  output logic [15:0] accel_read_data,
  input  logic [15:0] accel_write_data,
  output logic        overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Entry layout: bit 8 = released flag, bits 7:0 = scancode.
  logic [8:0]    mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          full;
  logic          not_empty;
  logic          flush;
  logic          pop_acc;
  logic          wr_en;
  logic          rd_adv;
  logic          lost;
  logic [8:0]    head_entry;

  // Only bit 0 of the control word has a meaning.
  logic          unused_wdata;
  assign unused_wdata = ^accel_write_data[15:1];

  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign flush     = accel_write_enable && accel_write_data[0];
  assign pop_acc   = accel_read_enable && not_empty;

  // A key event is lost whenever the FIFO is full and no pop makes room.
  assign lost      = key_valid && full && !pop_acc;

  // Decide which pointers move this cycle; flush suppresses everything else.
  always_comb begin
    wr_en  = 1'b0;
    rd_adv = 1'b0;
    if (!flush) begin
`ifdef KEYBOARD_ACCEL_ADAPTER_DROP_OLDEST_EN
      // Every event is stored; when full the oldest entry is pushed out.
      wr_en  = key_valid;
      rd_adv = pop_acc || lost;
`else
      // Events that find no room are dropped.
      wr_en  = key_valid && (!full || pop_acc);
      rd_adv = pop_acc;
`endif
    end
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_en && !rd_adv) begin
        count_d = count_q + CW'(1);
      end else if (rd_adv && !wr_en) begin
        count_d = count_q - CW'(1);
      end
      if (lost) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control state; cleared asynchronously so buffered events vanish at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Event storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {key_released, key_code};
    end
  end

  // Show-ahead head word, forced to zero when nothing is buffered.
  assign head_entry      = mem_q[rd_ptr_q];
  assign accel_can_read  = not_empty;
  assign accel_can_write = 1'b1;
  assign accel_read_data = not_empty ? {head_entry[8], 7'b0, head_entry[7:0]} : 16'h0000;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_keyboard_accel_adapter.sv
// Bench for keyboard_accel_adapter (DEPTH = 4). Read words are checked by a
// scoreboard monitor; status flags are checked directly after each step.
// Expectations follow KEYBOARD_ACCEL_ADAPTER_DROP_OLDEST_EN when it is defined.
module tb_keyboard_accel_adapter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        key_released = 1'b0;
  logic        accel_can_read;
  logic        accel_can_write;
  logic        accel_read_enable = 1'b0;
  logic        accel_write_enable = 1'b0;
  logic [15:0] accel_read_data;
  logic [15:0] accel_write_data = 16'h0000;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  keyboard_accel_adapter #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .key_valid          (key_valid),
    .key_code           (key_code),
    .key_released       (key_released),
    .accel_can_read     (accel_can_read),
    .accel_can_write    (accel_can_write),
    .accel_read_enable  (accel_read_enable),
    .accel_write_enable (accel_write_enable),
    .accel_read_data    (accel_read_data),
    .accel_write_data   (accel_write_data),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, actual, expected);
    end else begin
      $display("ok   %s: 0x%04h", name, actual);
    end
  endtask

  // Monitor: each accepted read strobe pops one expected word and compares it
  // with the word presented just before the consuming edge.
  always @(negedge clk) begin
    if (rst_n && accel_read_enable) begin
      logic [15:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got 0x%04h with no expectation queued", accel_read_data);
      end else begin
        e = exp_q.pop_front();
        check("read_word", accel_read_data, e);
      end
    end
  end

  // One clock cycle of stimulus; inputs return to idle after the edge.
  task automatic step(input logic kv, input logic [7:0] code, input logic rel,
                      input logic re, input logic [15:0] exp_word,
                      input logic we, input logic [15:0] wd);
    key_valid          = kv;
    key_code           = code;
    key_released       = rel;
    accel_read_enable  = re;
    accel_write_enable = we;
    accel_write_data   = wd;
    if (re) exp_q.push_back(exp_word);
    @(posedge clk);
    #1;
    key_valid          = 1'b0;
    key_released       = 1'b0;
    accel_read_enable  = 1'b0;
    accel_write_enable = 1'b0;
    accel_write_data   = 16'h0000;
  endtask

  task automatic push(input logic [7:0] code, input logic rel);
    step(1'b1, code, rel, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic rd(input logic [15:0] exp_word);
    step(1'b0, 8'h00, 1'b0, 1'b1, exp_word, 1'b0, 16'h0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_can_read", {15'b0, accel_can_read}, 16'h0);
    check("rst_read_data", accel_read_data, 16'h0000);
    check("rst_can_write", {15'b0, accel_can_write}, 16'h1);
    check("rst_overflow", {15'b0, overflow}, 16'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single make event, one-cycle latency, then drain
    push(8'h1C, 1'b0);
    check("push1_can_read", {15'b0, accel_can_read}, 16'h1);
    check("push1_data", accel_read_data, 16'h001C);
    rd(16'h001C);
    check("pop1_can_read", {15'b0, accel_can_read}, 16'h0);
    check("pop1_data", accel_read_data, 16'h0000);

    // Break then make, back-to-back reads
    push(8'hF0, 1'b1);
    push(8'h32, 1'b0);
    rd(16'h80F0);
    rd(16'h0032);
    check("b2b_empty", {15'b0, accel_can_read}, 16'h0);

    // Overflow with five pushes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b0);
    check("ovf_set", {15'b0, overflow}, 16'h1);
`ifdef KEYBOARD_ACCEL_ADAPTER_DROP_OLDEST_EN
    for (int i = 2; i <= 5; i++) rd(16'(i));
`else
    for (int i = 1; i <= 4; i++) rd(16'(i));
`endif
    check("ovf_drained", {15'b0, accel_can_read}, 16'h0);
    check("ovf_sticky", {15'b0, overflow}, 16'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0001);
    check("flush_clears_ovf", {15'b0, overflow}, 16'h0);

    // Full FIFO with simultaneous push and pop loses nothing
    for (int i = 5; i <= 8; i++) push(8'(i), 1'b0);
    step(1'b1, 8'h09, 1'b0, 1'b1, 16'h0005, 1'b0, 16'h0);
    check("full_pushpop_ovf", {15'b0, overflow}, 16'h0);
    rd(16'h0006);
    rd(16'h0007);
    rd(16'h0008);
    rd(16'h0009);
    check("full_pushpop_empty", {15'b0, accel_can_read}, 16'h0);

    // Three entries with overflow set; no-op write, then flush vs push
    for (int i = 8'h11; i <= 8'h15; i++) push(8'(i), 1'b0);
`ifdef KEYBOARD_ACCEL_ADAPTER_DROP_OLDEST_EN
    rd(16'h0012);
`else
    rd(16'h0011);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000);
    check("nop_write_can_read", {15'b0, accel_can_read}, 16'h1);
    check("nop_write_ovf", {15'b0, overflow}, 16'h1);
`ifdef KEYBOARD_ACCEL_ADAPTER_DROP_OLDEST_EN
    check("nop_write_head", accel_read_data, 16'h0013);
`else
    check("nop_write_head", accel_read_data, 16'h0012);
`endif
    step(1'b1, 8'h44, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0001);
    check("flush_can_read", {15'b0, accel_can_read}, 16'h0);
    check("flush_ovf", {15'b0, overflow}, 16'h0);
    check("flush_data", accel_read_data, 16'h0000);
    rd(16'h0000);
    check("empty_read_ignored", {15'b0, accel_can_read}, 16'h0);
    push(8'h20, 1'b0);
    rd(16'h0020);
    check("after_flush_empty", {15'b0, accel_can_read}, 16'h0);

    // Asynchronous reset between edges discards buffered events
    push(8'h21, 1'b0);
    push(8'h22, 1'b1);
    check("pre_areset_can_read", {15'b0, accel_can_read}, 16'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_can_read", {15'b0, accel_can_read}, 16'h0);
    check("areset_data", accel_read_data, 16'h0000);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(8'h10, 1'b0);
    rd(16'h0010);
    check("post_reset_empty", {15'b0, accel_can_read}, 16'h0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keyboard_accel_adapter.md
# keyboard_accel_adapter

- Read-direction accelerator adapter: buffers key events from the keyboard decoder in a FIFO and returns them to the CPU through the accelerator port, using `accel_can_read` / `accel_read_enable` / `accel_read_data`.
- Sits between the keyboard scancode decoder and the CPU accelerator bus, alongside the write-only drawing adapters.
- CPU writes are used only for control: flush.

## Interface
- `DEPTH`, 16: FIFO depth in events. Must be a power of two, minimum 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  single-cycle strobe from the decoder; event present.
- `key_code`  in  8  scancode, qualified by `key_valid`.
- `key_released`  in  1  1 = break (release), 0 = make; qualified by `key_valid`.
- `accel_can_read`  out  1  FIFO non-empty; a word is available.
- `accel_can_write`  out  1  control write accepted; constant 1.
- `accel_read_enable`  in  1  CPU pops the head word; ignored unless `accel_can_read`.
- `accel_write_enable`  in  1  CPU control write.
- `accel_read_data`  out  16  head word: `{key_released, 7'b0, key_code}`; 0 when empty.
- `accel_write_data`  in  16  control word; bit 0 = flush; other bits ignored.
- `overflow`  out  1  sticky flag; set when an event is lost.

## Operation
- Storage: `DEPTH` × 9-bit entries (released flag + code).
- Pointers: write pointer and read pointer, each `log2(DEPTH)` bits; they wrap modulo `DEPTH`.
- Occupancy counter: `count`, `log2(DEPTH)+1` bits, range 0..`DEPTH`.
- Push: `key_valid` and not full → store the entry at the write pointer, advance it, increment `count`.
- Pop: `accel_read_enable && accel_can_read` → advance the read pointer, decrement `count`.
- Simultaneous push and pop: both pointers advance and `count` is unchanged. This applies when full as well: the push is accepted, nothing is lost, `overflow` does not set.
- Push while full with no pop: the event is dropped and `overflow` is set (but see Configuration).
- `accel_read_enable` while empty: ignored; no pointer or `count` change.
- Flush: `accel_write_enable && accel_write_data[0]`.
  - Pointers and `count` go to 0; `overflow` clears.
  - Flush wins over a simultaneous push or pop in the same cycle; that pushed event is discarded.
  - A write with bit 0 = 0 has no effect.
- `accel_read_data` is combinational from storage at the read pointer, gated by `accel_can_read` (show-ahead).

## Timing
- Reset values (`rst_n` low, asynchronous): both pointers 0, `count` 0, `overflow` 0, `accel_can_read` 0, `accel_read_data` 0, `accel_can_write` 1.
- Storage contents are not reset.
- Reset asserted mid-operation discards all buffered events immediately.
- Push latency: `key_valid` at edge N → `accel_can_read` = 1 and the word visible from after edge N (one cycle).
- Pop: read at edge N → the next word, or `accel_can_read` = 0, is visible after edge N.
  - Back-to-back reads, one per cycle, are supported.
- Flush at edge N → `accel_can_read` = 0 and `overflow` = 0 after edge N.
- `overflow` sets on the edge where the drop (or overwrite) happens and holds until flush or reset.

## Configuration
- Macro: `KEYBOARD_ACCEL_ADAPTER_DROP_OLDEST_EN`.
- Defined: a push while full with no pop overwrites the oldest entry.
  - Write and read pointers both advance; `count` stays at `DEPTH`.
  - `overflow` sets.
  - The CPU always sees the newest `DEPTH` events.
- Undefined (default): the new event is dropped; storage and pointers are unchanged; `overflow` sets.

## Test plan
- Reset, then push code 0x1C (make) → `accel_can_read` = 1 next cycle, `accel_read_data` = 0x001C. Read once → `accel_can_read` = 0, data = 0x0000.
- Push 0xF0 with `key_released` = 1, then 0x32 make, then read twice on consecutive cycles → reads return 0x80F0 then 0x0032 in order; FIFO empties.
- `DEPTH` = 4: push 5 events 0x01..0x05 with no reads.
  - Without macro: reads return 0x01..0x04, `overflow` = 1.
  - With macro: reads return 0x02..0x05, `overflow` = 1.
- Fill to 4 entries, then in one cycle push 0x09 and read → `overflow` stays 0, `count` stays 4, and the last read after draining returns 0x0009.
- With 3 entries buffered and `overflow` = 1, write 0x0001 in the same cycle as `key_valid` (0x44) → `accel_can_read` = 0, `overflow` = 0, and 0x44 is not stored. A write of 0x0000 changes nothing.
- Pulse `rst_n` low asynchronously (between clock edges) with 2 entries buffered → `accel_can_read` falls without a clock edge. After release, a new push of 0x10 reads back as 0x0010.
